// File: rtl/game_control.sv
// game_control: frame-paced FSM that sequences map/sprite redraws and player actions
module game_control #(
    parameter int FRAME_CYCLES    = 833333,
    parameter int ATTACK_COOLDOWN = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_attack,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       draw_map_done,
    input  logic       draw_link_done,
    output logic       init,
    output logic       idle,
    output logic       attack,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       draw_map,
    output logic       draw_link,
    output logic [3:0] state_dbg,
    output logic       frame_overrun
);
    localparam int FW = $clog2(FRAME_CYCLES);
    localparam int CW = $clog2(ATTACK_COOLDOWN + 2);
    localparam logic [3:0] S_RESET     = 4'd0;
    localparam logic [3:0] S_INIT      = 4'd1;
    localparam logic [3:0] S_DRAW_MAP  = 4'd2;
    localparam logic [3:0] S_DRAW_LINK = 4'd3;
    localparam logic [3:0] S_WAIT      = 4'd4;
    localparam logic [3:0] S_ATTACK    = 4'd5;
    localparam logic [3:0] S_UP        = 4'd6;
    localparam logic [3:0] S_DOWN      = 4'd7;
    localparam logic [3:0] S_LEFT      = 4'd8;
    localparam logic [3:0] S_RIGHT     = 4'd9;

    logic [FW-1:0] frame_cnt;
    logic [CW-1:0] cooldown;
    logic [3:0]    state, state_nx;
    logic          frame_tick, pending, consume, attack_ready;

    assign frame_tick = frame_cnt == FW'(FRAME_CYCLES - 1);
    assign consume    = state == S_WAIT && pending;
    assign state_dbg  = state;

    // free-running frame counter, independent of the FSM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) frame_cnt <= '0;
        else        frame_cnt <= frame_tick ? '0 : frame_cnt + 1'b1;
    end

    // pending frame flag; a new tick outranks consumption, a tick on a set flag is an overrun
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending       <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            pending       <= frame_tick | (pending & ~consume);
            frame_overrun <= frame_overrun | (frame_tick & pending);
        end
    end

    // cooldown counts frames; attack eligibility is taken at the tick, before that tick's decrement
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cooldown     <= '0;
            attack_ready <= 1'b0;
        end else begin
            if (frame_tick) attack_ready <= cooldown == '0;
            if (state_nx == S_ATTACK)           cooldown <= CW'(ATTACK_COOLDOWN);
            else if (frame_tick && cooldown != '0) cooldown <= cooldown - 1'b1;
        end
    end

    // next-state decode; buttons only matter when a frame is pending in WAIT
    always_comb begin
        state_nx = state;
        case (state)
            S_RESET:     state_nx = S_INIT;
            S_INIT:      state_nx = S_DRAW_MAP;
            S_DRAW_MAP:  state_nx = draw_map_done  ? S_DRAW_LINK : S_DRAW_MAP;
            S_DRAW_LINK: state_nx = draw_link_done ? S_WAIT      : S_DRAW_LINK;
            S_WAIT:      state_nx = !pending                   ? S_WAIT   :
                                    btn_attack && attack_ready ? S_ATTACK :
                                    btn_up                     ? S_UP     :
                                    btn_down                   ? S_DOWN   :
                                    btn_left                   ? S_LEFT   :
                                    btn_right                  ? S_RIGHT  : S_WAIT;
            S_ATTACK, S_UP, S_DOWN, S_LEFT, S_RIGHT: state_nx = S_DRAW_MAP;
            default:     state_nx = S_RESET;
        endcase
    end

    // state register with registered one-hot strobes decoded from the next state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_RESET;
            {init, idle, attack, up, down, left, right, draw_map, draw_link} <= '0;
        end else begin
            state     <= state_nx;
            init      <= state_nx == S_INIT;
            idle      <= state_nx == S_WAIT;
            attack    <= state_nx == S_ATTACK;
            up        <= state_nx == S_UP;
            down      <= state_nx == S_DOWN;
            left      <= state_nx == S_LEFT;
            right     <= state_nx == S_RIGHT;
            draw_map  <= state_nx == S_DRAW_MAP;
            draw_link <= state_nx == S_DRAW_LINK;
        end
    end
endmodule

// File: tb/tb_game_control.sv
// tb_game_control: table vectors plus scoreboarded action strobes for game_control
module tb_game_control;
    localparam int F  = 10;
    localparam int CD = 2;

    logic clock = 1'b0, reset = 1'b0;
    logic btn_attack, btn_up, btn_down, btn_left, btn_right;
    logic draw_map_done, draw_link_done;
    logic init, idle, attack, up, down, left, right, draw_map, draw_link, frame_overrun;
    logic [3:0] state_dbg;
    logic [8:0] strobes;
    logic [4:0] acts, e;
    logic [4:0] exp_q[$];
    int vectors = 0, miscompares = 0, cyc = 0, left_cnt;
    int pat[6] = '{1, 0, 0, 1, 0, 0};

    typedef struct {
        logic [4:0] btn;
        logic [4:0] act;
    } vec_t;
    vec_t tbl[12];

    assign strobes = {init, idle, attack, up, down, left, right, draw_map, draw_link};
    assign acts    = {attack, up, down, left, right};

    always #5 clock = ~clock;

    game_control #(.FRAME_CYCLES(F), .ATTACK_COOLDOWN(CD)) dut (
        .clock(clock), .reset(reset),
        .btn_attack(btn_attack), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right),
        .draw_map_done(draw_map_done), .draw_link_done(draw_link_done),
        .init(init), .idle(idle), .attack(attack), .up(up), .down(down),
        .left(left), .right(right), .draw_map(draw_map), .draw_link(draw_link),
        .state_dbg(state_dbg), .frame_overrun(frame_overrun)
    );

    always @(posedge clock or negedge reset)
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;

    always @(negedge clock) if (reset) begin
        if ($countones(strobes) > 1) begin
            miscompares++;
            $display("FAIL onehot: strobes=%b, at most one may be high", strobes);
        end
        if (acts != 5'b0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_action: got %b, none expected", acts);
            end else begin
                e = exp_q.pop_front();
                if (acts !== e) begin
                    miscompares++;
                    $display("FAIL action: got %b expected %b", acts, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [4:0] b);
        {btn_attack, btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    task automatic goto_phase(input int p);
        for (int i = 0; i < 2 * F; i++) begin
            @(negedge clock);
            if (cyc % F == p) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl = '{'{5'b01000, 5'b01000}, '{5'b00100, 5'b00100}, '{5'b00010, 5'b00010},
                '{5'b00001, 5'b00001}, '{5'b01010, 5'b01000}, '{5'b00101, 5'b00100},
                '{5'b00011, 5'b00010}, '{5'b00000, 5'b00000}, '{5'b11000, 5'b10000},
                '{5'b10001, 5'b00001}, '{5'b10000, 5'b00000}, '{5'b10100, 5'b10000}};
        set_btn(5'b0);
        draw_map_done  = 1'b0;
        draw_link_done = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_state", state_dbg, 0);
        chk("reset_strobes", strobes, 0);
        chk("reset_overrun", frame_overrun, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("init_pulse", {state_dbg, init}, {4'd1, 1'b1});
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            chk("draw_map_hold", {state_dbg, draw_map}, {4'd2, 1'b1});
            if (i == 5) draw_map_done = 1'b1;
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            chk("draw_link_hold", {state_dbg, draw_map, draw_link}, {4'd3, 1'b0, 1'b1});
            if (i == 1) draw_map_done = 1'b0;
            if (i == 3) draw_link_done = 1'b1;
        end
        @(negedge clock);
        chk("wait_idle", {state_dbg, idle}, {4'd4, 1'b1});
        draw_map_done = 1'b1;
        foreach (tbl[i]) begin
            goto_phase(8);
            set_btn(tbl[i].btn);
            if (tbl[i].act != 5'b0) exp_q.push_back(tbl[i].act);
            goto_phase(2);
            chk($sformatf("vec%0d_state", i), state_dbg, tbl[i].act != 5'b0 ? 2 : 4);
            set_btn(5'b0);
        end
        goto_phase(2);
        goto_phase(2);
        goto_phase(8);
        btn_attack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (pat[k] != 0) exp_q.push_back(5'b10000);
            goto_phase(2);
            chk($sformatf("attack_tick%0d", k + 1), state_dbg, pat[k] != 0 ? 2 : 4);
        end
        set_btn(5'b0);
        goto_phase(8);
        draw_map_done = 1'b0;
        btn_up = 1'b1;
        exp_q.push_back(5'b01000);
        goto_phase(2);
        btn_up = 1'b0;
        chk("stall_state", state_dbg, 2);
        btn_left = 1'b1;
        exp_q.push_back(5'b00010);
        repeat (24) @(negedge clock);
        chk("overrun_set", {frame_overrun, state_dbg}, {1'b1, 4'd2});
        draw_map_done = 1'b1;
        left_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (left) begin
                left_cnt++;
                btn_left = 1'b0;
            end
        end
        btn_left = 1'b0;
        chk("deferred_once", left_cnt, 1);
        chk("overrun_sticky", frame_overrun, 1);
        goto_phase(8);
        draw_link_done = 1'b0;
        btn_right = 1'b1;
        exp_q.push_back(5'b00001);
        goto_phase(2);
        set_btn(5'b0);
        chk("pre_link_state", state_dbg, 2);
        repeat (3) @(negedge clock);
        chk("link_third", {state_dbg, draw_link}, {4'd3, 1'b1});
        #2 reset = 1'b0;
        #1 chk("async_reset", {state_dbg, strobes, frame_overrun}, 0);
        draw_link_done = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        btn_down = 1'b1;
        exp_q.push_back(5'b00100);
        @(negedge clock);
        chk("restart_init", {state_dbg, init}, {4'd1, 1'b1});
        for (int i = 2; i <= 10; i++) @(negedge clock);
        chk("first_tick_wait", state_dbg, 4);
        @(negedge clock);
        chk("first_tick_action", state_dbg, 7);
        set_btn(5'b0);
        repeat (5) @(negedge clock);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/game_control.md
GAME_CONTROL -- requirements
Module: game_control

Interface
REQ-001 Parameter FRAME_CYCLES, default 833333; clock cycles per game frame (60 Hz at 50 MHz); legal range 4 to 2^20.
REQ-002 Parameter ATTACK_COOLDOWN, default 15; number of frame ticks during which a new attack is ignored after an attack.
REQ-003 clock  in  1  system clock (CLOCK_50); sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-005 btn_attack, btn_up, btn_down, btn_left, btn_right  in  1 each  player commands, active-high, already synchronised and debounced.
REQ-006 draw_map_done  in  1  level from datapath; 1 when the map draw pass is complete.
REQ-007 draw_link_done  in  1  level from datapath; 1 when the Link sprite draw pass is complete.
REQ-008 init, idle, attack, up, down, left, right, draw_map, draw_link  out  1 each  datapath control strobes, registered, at most one high per cycle.
REQ-009 state_dbg  out  4  current state encoding, for LEDR display.
REQ-010 frame_overrun  out  1  sticky flag: a frame tick was lost.

Function
REQ-011 Free-running frame counter SHALL count 0..FRAME_CYCLES-1 and wrap; internal frame_tick SHALL be high for the one cycle when the count equals FRAME_CYCLES-1.
REQ-012 frame_tick SHALL set a pending flag; the flag SHALL be cleared only when WAIT consumes it.
REQ-013 If frame_tick occurs while pending is already 1, frame_overrun SHALL set and remain 1 until reset.
REQ-014 States: S_RESET(0), S_INIT(1), S_DRAW_MAP(2), S_DRAW_LINK(3), S_WAIT(4), S_ATTACK(5), S_UP(6), S_DOWN(7), S_LEFT(8), S_RIGHT(9); state_dbg SHALL equal the encoding.
REQ-015 S_RESET -> S_INIT unconditionally on the first clock after reset release; all strobes are 0 in S_RESET.
REQ-016 S_INIT SHALL last exactly 1 cycle with init=1, then go to S_DRAW_MAP.
REQ-017 S_DRAW_MAP SHALL hold draw_map=1 until draw_map_done is sampled 1, then go to S_DRAW_LINK; draw_map SHALL be 0 on the following cycle.
REQ-018 S_DRAW_LINK SHALL hold draw_link=1 until draw_link_done is sampled 1, then go to S_WAIT.
REQ-019 S_WAIT SHALL drive idle=1, and SHALL evaluate buttons only in a cycle where pending=1, consuming pending in that cycle.
REQ-020 Priority on evaluation: btn_attack (only if cooldown=0) > btn_up > btn_down > btn_left > btn_right; no eligible button means remain in S_WAIT with pending consumed.
REQ-021 S_ATTACK, S_UP, S_DOWN, S_LEFT and S_RIGHT SHALL each last exactly 1 cycle with the matching strobe high, then go to S_DRAW_MAP.
REQ-022 Entering S_ATTACK SHALL load the cooldown counter with ATTACK_COOLDOWN; each frame_tick SHALL decrement it while it is nonzero, and it SHALL saturate at 0.
REQ-023 If btn_attack is high while cooldown is nonzero, it SHALL be ignored and the next-priority button SHALL apply.
REQ-024 A frame_tick during draw states SHALL NOT abort the draw; it SHALL be serviced at the next S_WAIT cycle.
REQ-025 If a done input is already 1 on state entry, the draw strobe SHALL still be high for exactly 1 cycle.
REQ-026 Frame counter and state machine SHALL run independently; frame counter wrap SHALL NOT reset state.

Reset
REQ-027 Asserting reset (0) at any time, including mid-draw, SHALL immediately force state S_RESET, all strobes 0, frame counter 0, pending 0, cooldown 0, frame_overrun 0.
REQ-028 After release, the first init pulse SHALL occur exactly 1 cycle later, and the first frame_tick FRAME_CYCLES cycles after release.

Verification (FRAME_CYCLES=10, ATTACK_COOLDOWN=2)
REQ-029 Reset release; draw_map_done rises 5 cycles into S_DRAW_MAP; draw_link_done rises 3 cycles into S_DRAW_LINK -> init is 1 for 1 cycle, draw_map is 1 for 5 cycles, draw_link is 1 for 3 cycles, then idle=1 and state_dbg=4.
REQ-030 In S_WAIT, btn_up=btn_left=1 at a tick -> up=1 for 1 cycle, left never asserts, and the next state is S_DRAW_MAP.
REQ-031 Hold btn_attack=1 for 6 ticks, with draws completing in 1 cycle -> attack strobes at tick 1 and tick 4 only; intervening ticks give no action.
REQ-032 Hold draw_map_done=0 for 25 cycles -> frame_overrun=1 and stays 1; exactly one deferred action occurs after the draw completes.
REQ-033 Assert reset=0 in the third cycle of S_DRAW_LINK -> draw_link=0 in the same cycle, state_dbg=0, and on release the sequence restarts with init.
REQ-034 Throughout all scenarios, assert that at most one strobe is high in any cycle.
